// File: rtl/guass_skin_pipe.sv
// Four-stage Gaussian skin classifier on Cb/Cr with frame-synchronous shadow
// configuration and a per-frame skin-pixel counter for the gesture tracker.
module guass_skin_pipe #(
    parameter int     DATA_W      = 8,
    parameter int     COEF_W      = 16,
    parameter int     CNT_W       = 20,
    parameter int     MEAN_CB_DEF = 123,
    parameter int     MEAN_CR_DEF = 139,
    parameter int     K1_DEF      = 120,
    parameter int     K2_DEF      = 96,
    parameter int     K3_DEF      = 140,
    parameter longint THR_DEF     = 14 << 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] cb,
    input  logic [DATA_W-1:0] cr,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic              out_valid,
    output logic              out_sof,
    output logic              skin,
    output logic [CNT_W-1:0]  frame_count,
    output logic              count_valid
);
    localparam int DW     = DATA_W + 1;
    localparam int PROD_W = 2 * DW;
    localparam int P_W    = PROD_W + COEF_W + 1;
    localparam int RES_W  = P_W + 2;

    localparam logic [DATA_W-1:0]       MCB_D = DATA_W'(MEAN_CB_DEF);
    localparam logic [DATA_W-1:0]       MCR_D = DATA_W'(MEAN_CR_DEF);
    localparam logic [COEF_W-1:0]       K1_D  = COEF_W'(K1_DEF);
    localparam logic [COEF_W-1:0]       K2_D  = COEF_W'(K2_DEF);
    localparam logic [COEF_W-1:0]       K3_D  = COEF_W'(K3_DEF);
    localparam logic signed [RES_W-1:0] THR_D = RES_W'(THR_DEF);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
        return (&a) ? a : a + 1'b1;
    endfunction

    // The threshold field is wider than the bus, so the write word is sign-extended.
    function automatic logic signed [RES_W-1:0] thr_field(input logic [31:0] w);
        logic signed [63:0] w64;
        w64 = {{32{w[31]}}, w};
        return w64[RES_W-1:0];
    endfunction

    logic [DATA_W-1:0]       stg_mean_cb, stg_mean_cr, nxt_mean_cb, nxt_mean_cr;
    logic [DATA_W-1:0]       act_mean_cb, act_mean_cr, use_mean_cb, use_mean_cr;
    logic [COEF_W-1:0]       stg_k1, stg_k2, stg_k3, nxt_k1, nxt_k2, nxt_k3;
    logic [COEF_W-1:0]       act_k1, act_k2, act_k3, use_k1, use_k2, use_k3;
    logic signed [RES_W-1:0] stg_thr, nxt_thr, act_thr, use_thr;
    logic                    commit;

    always_comb begin
        nxt_mean_cb = stg_mean_cb;
        nxt_mean_cr = stg_mean_cr;
        nxt_k1      = stg_k1;
        nxt_k2      = stg_k2;
        nxt_k3      = stg_k3;
        nxt_thr     = stg_thr;
        if (cfg_we) begin
            case (cfg_addr)
                3'd0:    nxt_mean_cb = cfg_wdata[DATA_W-1:0];
                3'd1:    nxt_mean_cr = cfg_wdata[DATA_W-1:0];
                3'd2:    nxt_k1      = cfg_wdata[COEF_W-1:0];
                3'd3:    nxt_k2      = cfg_wdata[COEF_W-1:0];
                3'd4:    nxt_k3      = cfg_wdata[COEF_W-1:0];
                3'd5:    nxt_thr     = thr_field(cfg_wdata);
                default: ;
            endcase
        end
    end

    // The SOF pixel already sees the set it commits, including a same-cycle write.
    assign commit      = in_valid & in_sof;
    assign use_mean_cb = commit ? nxt_mean_cb : act_mean_cb;
    assign use_mean_cr = commit ? nxt_mean_cr : act_mean_cr;
    assign use_k1      = commit ? nxt_k1 : act_k1;
    assign use_k2      = commit ? nxt_k2 : act_k2;
    assign use_k3      = commit ? nxt_k3 : act_k3;
    assign use_thr     = commit ? nxt_thr : act_thr;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_mean_cb <= MCB_D;  stg_mean_cr <= MCR_D;
            stg_k1 <= K1_D;  stg_k2 <= K2_D;  stg_k3 <= K3_D;  stg_thr <= THR_D;
            act_mean_cb <= MCB_D;  act_mean_cr <= MCR_D;
            act_k1 <= K1_D;  act_k2 <= K2_D;  act_k3 <= K3_D;  act_thr <= THR_D;
        end else begin
            stg_mean_cb <= nxt_mean_cb;  stg_mean_cr <= nxt_mean_cr;
            stg_k1 <= nxt_k1;  stg_k2 <= nxt_k2;  stg_k3 <= nxt_k3;  stg_thr <= nxt_thr;
            if (commit) begin
                act_mean_cb <= nxt_mean_cb;  act_mean_cr <= nxt_mean_cr;
                act_k1 <= nxt_k1;  act_k2 <= nxt_k2;  act_k3 <= nxt_k3;  act_thr <= nxt_thr;
            end
        end
    end

    logic                     vld_p0, sof_p0, vld_p1, sof_p1, vld_p2, sof_p2;
    logic signed [DW-1:0]     d1_p0, d2_p0;
    logic signed [PROD_W-1:0] sq1_p1, cross_p1, sq2_p1;
    logic signed [P_W-1:0]    t1_p2, t2_p2, t3_p2;
    logic [COEF_W-1:0]        k1_p0, k2_p0, k3_p0, k1_p1, k2_p1, k3_p1;
    logic signed [RES_W-1:0]  thr_p0, thr_p1, thr_p2, sum_p2;
    logic                     skin_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;  sof_p0 <= 1'b0;
            vld_p1 <= 1'b0;  sof_p1 <= 1'b0;
            vld_p2 <= 1'b0;  sof_p2 <= 1'b0;
            out_valid <= 1'b0;  out_sof <= 1'b0;  skin <= 1'b0;
        end else begin
            vld_p0 <= in_valid;  sof_p0 <= commit;
            vld_p1 <= vld_p0;    sof_p1 <= sof_p0;
            vld_p2 <= vld_p1;    sof_p2 <= sof_p1;
            out_valid <= vld_p2; out_sof <= sof_p2;  skin <= vld_p2 & skin_d;
        end
    end

    always_ff @(posedge clk) begin
        // S1: chroma offsets; the selected config set travels with the pixel
        d1_p0  <= $signed({1'b0, cb}) - $signed({1'b0, use_mean_cb});
        d2_p0  <= $signed({1'b0, cr}) - $signed({1'b0, use_mean_cr});
        k1_p0  <= use_k1;  k2_p0 <= use_k2;  k3_p0 <= use_k3;  thr_p0 <= use_thr;
        // S2: second-order products
        sq1_p1   <= PROD_W'(d1_p0) * PROD_W'(d1_p0);
        cross_p1 <= PROD_W'(d1_p0) * PROD_W'(d2_p0);
        sq2_p1   <= PROD_W'(d2_p0) * PROD_W'(d2_p0);
        k1_p1  <= k1_p0;  k2_p1 <= k2_p0;  k3_p1 <= k3_p0;  thr_p1 <= thr_p0;
        // S3: coefficient terms
        t1_p2  <= P_W'(sq1_p1)   * P_W'($signed({1'b0, k1_p1}));
        t2_p2  <= P_W'(cross_p1) * P_W'($signed({1'b0, k2_p1}));
        t3_p2  <= P_W'(sq2_p1)   * P_W'($signed({1'b0, k3_p1}));
        thr_p2 <= thr_p1;
    end

    // S4: full-width sum and signed compare
    assign sum_p2 = RES_W'(t1_p2) - RES_W'(t2_p2) + RES_W'(t3_p2);
    assign skin_d = sum_p2 < thr_p2;

    logic [CNT_W-1:0] acc;
    logic             seen_sof;

    // Counter tracks the S4 result so count_valid lines up with the out_sof pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;  seen_sof <= 1'b0;  frame_count <= '0;  count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (vld_p2) begin
                if (sof_p2) begin
                    if (seen_sof) begin
                        frame_count <= acc;
                        count_valid <= 1'b1;
                    end
                    seen_sof <= 1'b1;
                    acc      <= CNT_W'(skin_d);
                end else if (skin_d) begin
                    acc <= sat_inc(acc);
                end
            end
        end
    end
endmodule

// File: tb/tb_guass_skin_pipe.sv
// Directed bench for guass_skin_pipe: latency, classification, shadow config,
// frame counting, counter saturation (CNT_W=2 instance) and reset in flight.
module tb_guass_skin_pipe;
    logic        clk, rst, in_valid, in_sof, cfg_we;
    logic [7:0]  cb, cr;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        out_valid, out_sof, skin, count_valid;
    logic [19:0] frame_count;
    logic        out_valid2, out_sof2, skin2, count_valid2;
    logic [1:0]  frame_count2;
    int          checks = 0;
    int          failures = 0;

    guass_skin_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .cb(cb), .cr(cr),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .out_valid(out_valid), .out_sof(out_sof), .skin(skin),
        .frame_count(frame_count), .count_valid(count_valid)
    );

    guass_skin_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .cb(cb), .cr(cr),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .out_valid(out_valid2), .out_sof(out_sof2), .skin(skin2),
        .frame_count(frame_count2), .count_valid(count_valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One input cycle; on return the output of the pixel driven three calls earlier is visible.
    task automatic cyc(input logic v, input logic s, input logic [7:0] b, input logic [7:0] r);
        in_valid = v; in_sof = s; cb = b; cr = r;
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        if (out_sof !== 1'b0) begin failures++; $display("FAIL rst_out_sof got=%0b exp=0", out_sof); end
        if (skin !== 1'b0) begin failures++; $display("FAIL rst_skin got=%0b exp=0", skin); end
        if (count_valid !== 1'b0) begin failures++; $display("FAIL rst_count_valid got=%0b exp=0", count_valid); end
        if (frame_count !== 20'd0) begin failures++; $display("FAIL rst_frame_count got=%0d exp=0", frame_count); end
        if (frame_count2 !== 2'd0) begin failures++; $display("FAIL rst_frame_count2 got=%0d exp=0", frame_count2); end
    endtask

    task automatic test_centre();
        cyc(1, 0, 8'd123, 8'd139);
        cyc(0, 0, 8'd0, 8'd0);
        cyc(0, 0, 8'd0, 8'd0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL centre_early got=%0b exp=0", out_valid); end
        cyc(0, 0, 8'd0, 8'd0);
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL centre_valid got=%0b exp=1", out_valid); end
        if (skin !== 1'b1) begin failures++; $display("FAIL centre_skin got=%0b exp=1", skin); end
        if (out_sof !== 1'b0) begin failures++; $display("FAIL centre_sof got=%0b exp=0", out_sof); end
        cyc(0, 0, 8'd0, 8'd0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL centre_after got=%0b exp=0", out_valid); end
    endtask

    task automatic test_far();
        bit ev[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        bit es[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
        cyc(1, 0, 8'd0, 8'd255);
        repeat (3) cyc(0, 0, 8'd0, 8'd0);
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL far_valid got=%0b exp=1", out_valid); end
        if (skin !== 1'b0) begin failures++; $display("FAIL far_skin got=%0b exp=0", skin); end
        for (int i = 0; i < 11; i++) begin
            if (i < 8) cyc(ev[i], 0, es[i] ? 8'd123 : 8'd0, es[i] ? 8'd139 : 8'd255);
            else       cyc(0, 0, 8'd0, 8'd0);
            if (i >= 3) begin
                checks++;
                if (out_valid !== ev[i-3]) begin
                    failures++; $display("FAIL stream_valid[%0d] got=%0b exp=%0b", i-3, out_valid, ev[i-3]);
                end
                if (ev[i-3]) begin
                    checks++;
                    if (skin !== es[i-3]) begin
                        failures++; $display("FAIL stream_skin[%0d] got=%0b exp=%0b", i-3, skin, es[i-3]);
                    end
                end
            end
        end
    endtask

    task automatic test_shadow();
        bit         sf[5] = '{1, 0, 0, 1, 0};
        logic [7:0] sb[5] = '{8'd123, 8'd123, 8'd123, 8'd100, 8'd123};
        bit         es[5] = '{1, 1, 1, 0, 0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 1) cfg(3'd5, 32'd0);
            if (i == 3) cfg(3'd0, 32'd100);
            if (i < 5) cyc(1, sf[i], sb[i], 8'd139);
            else       cyc(0, 0, 8'd0, 8'd0);
            if (i >= 3) begin
                checks += 2;
                if (out_valid !== 1'b1) begin failures++; $display("FAIL shadow_valid[%0d] got=%0b exp=1", i-3, out_valid); end
                if (skin !== es[i-3]) begin failures++; $display("FAIL shadow_skin[%0d] got=%0b exp=%0b", i-3, skin, es[i-3]); end
            end
        end
    endtask

    task automatic test_frame_count();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            if (i <= 10) begin
                if (i == 2 || i == 5 || i == 8) cyc(1, 0, 8'd123, 8'd139);
                else cyc(1, (i == 0 || i == 10), 8'd0, 8'd255);
            end else cyc(0, 0, 8'd0, 8'd0);
            if (i >= 3) begin
                checks += 2;
                if (count_valid !== (i - 3 == 10)) begin
                    failures++; $display("FAIL frame_pulse[%0d] got=%0b exp=%0b", i-3, count_valid, (i - 3 == 10));
                end
                if (count_valid2 !== (i - 3 == 10)) begin
                    failures++; $display("FAIL frame_pulse2[%0d] got=%0b exp=%0b", i-3, count_valid2, (i - 3 == 10));
                end
                if (i - 3 == 0) begin
                    checks++;
                    if (frame_count !== 20'd0) begin failures++; $display("FAIL first_sof_count got=%0d exp=0", frame_count); end
                end
                if (i - 3 == 10) begin
                    checks += 3;
                    if (frame_count !== 20'd3) begin failures++; $display("FAIL frame_count got=%0d exp=3", frame_count); end
                    if (frame_count2 !== 2'd3) begin failures++; $display("FAIL frame_count2 got=%0d exp=3", frame_count2); end
                    if (out_sof !== 1'b1) begin failures++; $display("FAIL frame_out_sof got=%0b exp=1", out_sof); end
                end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            if (i <= 5)      cyc(1, (i == 0), 8'd123, 8'd139);
            else if (i == 6) cyc(1, 1, 8'd0, 8'd255);
            else             cyc(0, 0, 8'd0, 8'd0);
            if (i >= 3 && i - 3 <= 5) begin
                checks += 2;
                if (out_valid2 !== 1'b1) begin failures++; $display("FAIL sat_valid[%0d] got=%0b exp=1", i-3, out_valid2); end
                if (skin2 !== 1'b1) begin failures++; $display("FAIL sat_skin[%0d] got=%0b exp=1", i-3, skin2); end
            end
            if (i - 3 == 6) begin
                checks += 5;
                if (count_valid !== 1'b1) begin failures++; $display("FAIL sat_pulse got=%0b exp=1", count_valid); end
                if (count_valid2 !== 1'b1) begin failures++; $display("FAIL sat_pulse2 got=%0b exp=1", count_valid2); end
                if (frame_count !== 20'd6) begin failures++; $display("FAIL six_count got=%0d exp=6", frame_count); end
                if (frame_count2 !== 2'd3) begin failures++; $display("FAIL sat_count got=%0d exp=3", frame_count2); end
                if (out_sof2 !== 1'b1) begin failures++; $display("FAIL sat_out_sof got=%0b exp=1", out_sof2); end
            end
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        cyc(1, 1, 8'd123, 8'd139);
        cyc(1, 0, 8'd123, 8'd139);
        cfg(3'd5, 32'd0);
        cyc(1, 0, 8'd123, 8'd139);
        cyc(1, 1, 8'd0, 8'd255);
        cyc(1, 0, 8'd123, 8'd139);
        cyc(1, 0, 8'd123, 8'd139);
        cyc(1, 0, 8'd123, 8'd139);
        checks += 2;
        if (count_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_pulse got=%0b exp=1", count_valid); end
        if (frame_count !== 20'd3) begin failures++; $display("FAIL pre_rst_count got=%0d exp=3", frame_count); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'd0, 8'd0);
            checks += 3;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid[%0d] got=%0b exp=0", i, out_valid); end
            if (count_valid !== 1'b0) begin failures++; $display("FAIL flush_pulse[%0d] got=%0b exp=0", i, count_valid); end
            if (frame_count !== 20'd0) begin failures++; $display("FAIL flush_count[%0d] got=%0d exp=0", i, frame_count); end
        end
        cyc(1, 0, 8'd123, 8'd139);
        repeat (3) cyc(0, 0, 8'd0, 8'd0);
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL def_valid got=%0b exp=1", out_valid); end
        if (skin !== 1'b1) begin failures++; $display("FAIL def_thr_skin got=%0b exp=1", skin); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; cb = '0; cr = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        test_reset();
        test_centre();
        test_far();
        test_shadow();
        test_frame_count();
        test_saturation();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
